// File: rtl/rr_priority_arbiter.sv
// Clocked round-robin / fixed-priority arbiter for the router switch control.
// A grant is held from the winning arbitration until the owner releases it.
module rr_priority_arbiter #(
    parameter int size        = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [size-1:0]          requests,
    input  logic                     enable,
    // 'release' is a reserved word in SystemVerilog
    input  logic                     release_grant,
    output logic                     isOutputSelected,
    output logic [$clog2(size)-1:0]  selectedOutput,
    output logic [size-1:0]          grant
);

    localparam int IDX_W = $clog2(size);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] pointer_q, pointer_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [size-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;

    logic [IDX_W-1:0] winner;
    logic             found;
    logic [IDX_W-1:0] cand;
    logic [31:0]      scan_idx;

    // Search upward from the pointer, wrapping at size-1 (size need not be 2^n).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        winner   = '0;
        found    = 1'b0;
        cand     = '0;
        scan_idx = '0;
        for (int k = 0; k < size; k++) begin
            scan_idx = 32'(pointer_q) + 32'(k);
            if (scan_idx >= 32'(size)) begin
                scan_idx = scan_idx - 32'(size);
            end
            cand = IDX_W'(scan_idx);
            if (!found && requests[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        unique case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d        = BUSY;
                    sel_d          = winner;
                    grant_d        = '0;
                    grant_d[winner] = 1'b1;
                    valid_d        = 1'b1;
                end
            end
            BUSY: begin
                // The release edge only frees the grant; arbitration resumes next edge.
                if (release_grant) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    if (ROUND_ROBIN != 0) begin
                        pointer_d = (sel_q == IDX_W'(size - 1)) ? '0 : sel_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
        end
    end

    assign isOutputSelected = valid_q;
    assign selectedOutput   = sel_q;
    assign grant            = grant_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: three instances (size 8 RR, size 5 RR, size 8 fixed)
// checked every cycle against a queue-free behavioural model, plus directed literals.
module tb_rr_priority_arbiter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       rel;
    logic [7:0] req8, reqf;
    logic [4:0] req5;

    logic       valid8, valid5, validf;
    logic [2:0] sel8, sel5, self;
    logic [7:0] grant8, grantf;
    logic [4:0] grant5;

    int total = 0;
    int bad   = 0;

    rr_priority_arbiter #(.size(8), .ROUND_ROBIN(1)) dut8 (
        .clock(clock), .reset(reset), .requests(req8), .enable(enable),
        .release_grant(rel), .isOutputSelected(valid8), .selectedOutput(sel8), .grant(grant8));

    rr_priority_arbiter #(.size(5), .ROUND_ROBIN(1)) dut5 (
        .clock(clock), .reset(reset), .requests(req5), .enable(enable),
        .release_grant(rel), .isOutputSelected(valid5), .selectedOutput(sel5), .grant(grant5));

    rr_priority_arbiter #(.size(8), .ROUND_ROBIN(0)) dutf (
        .clock(clock), .reset(reset), .requests(reqf), .enable(enable),
        .release_grant(rel), .isOutputSelected(validf), .selectedOutput(self), .grant(grantf));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Uniform views of the three instances.
    logic [31:0] rq [3];
    logic [31:0] ag [3];
    logic [31:0] as [3];
    logic        av [3];
    assign rq[0] = 32'(req8);   assign rq[1] = 32'(req5);   assign rq[2] = 32'(reqf);
    assign ag[0] = 32'(grant8); assign ag[1] = 32'(grant5); assign ag[2] = 32'(grantf);
    assign as[0] = 32'(sel8);   assign as[1] = 32'(sel5);   assign as[2] = 32'(self);
    assign av[0] = valid8;      assign av[1] = valid5;      assign av[2] = validf;

    int n_of  [3] = '{8, 5, 8};
    int rr_of [3] = '{1, 1, 0};

    int m_busy  [3];
    int m_owner [3];
    int m_ptr   [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [31:0] r, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    // Behavioural model: owner/pointer bookkeeping straight from the arbitration rules.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                m_busy[d] = 0; m_owner[d] = 0; m_ptr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (m_busy[d] != 0) begin
                    if (rel) begin
                        m_busy[d] = 0;
                        if (rr_of[d] != 0) m_ptr[d] = (m_owner[d] + 1) % n_of[d];
                    end
                end else if (enable && rq[d] != 0) begin
                    m_owner[d] = pick(rq[d], m_ptr[d], n_of[d]);
                    m_busy[d]  = 1;
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            check($sformatf("cmp%0d_valid", d), 32'(av[d]), 32'(m_busy[d] != 0));
            check($sformatf("cmp%0d_grant", d), ag[d],
                  (m_busy[d] != 0) ? (32'd1 << m_owner[d]) : 32'd0);
            if (m_busy[d] != 0) check($sformatf("cmp%0d_sel", d), as[d], 32'(m_owner[d]));
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rel = 1'b0;
        req8 = '0; req5 = '0; reqf = '0;
        cyc(); cyc();
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_grant", 32'(grant8), 32'd0);
        check("rst_sel",   32'(sel8),   32'd0);
        reset = 1'b0;
        cyc();

        // Async reset while port 5 owns the grant.
        req8 = 8'h20; enable = 1'b1;
        cyc();
        check("t1_owner5_sel",   32'(sel8),   32'd5);
        check("t1_owner5_grant", 32'(grant8), 32'h20);
        req8 = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("t1_async_valid", 32'(valid8), 32'd0);
        check("t1_async_grant", 32'(grant8), 32'd0);
        check("t1_async_sel",   32'(sel8),   32'd0);
        cyc();
        reset = 1'b0; req8 = 8'hFF;
        cyc();
        check("t1_post_reset_grant", 32'(grant8), 32'h01);
        rel = 1'b1; req8 = 8'h00;
        cyc();
        rel = 1'b0;

        // Single request, grant held after request drops.
        req8 = 8'h04;
        cyc();
        check("t2_grant", 32'(grant8), 32'h04);
        check("t2_sel",   32'(sel8),   32'd2);
        check("t2_valid", 32'(valid8), 32'd1);
        req8 = 8'h00;
        repeat (3) cyc();
        check("t2_held_grant", 32'(grant8), 32'h04);
        rel = 1'b1;
        cyc();
        check("t2_released", 32'(valid8), 32'd0);
        rel = 1'b0;

        // Rotation 0..7,0 with one idle cycle between grants.
        reset = 1'b1;
        cyc();
        reset = 1'b0; req8 = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check($sformatf("t3_grant%0d", i), 32'(grant8), 32'd1 << (i % 8));
            rel = 1'b1;
            cyc();
            check($sformatf("t3_gap%0d", i), 32'(valid8), 32'd0);
            rel = 1'b0;
        end
        req8 = 8'h00;

        // size=5 wrap: owner 4 released, next winner is 0.
        req5 = 5'b10000;
        cyc();
        check("t4_owner4", 32'(sel5), 32'd4);
        rel = 1'b1; req5 = 5'b10001;
        cyc();
        check("t4_gap", 32'(valid5), 32'd0);
        rel = 1'b0;
        cyc();
        check("t4_wrap_sel",   32'(sel5),   32'd0);
        check("t4_wrap_grant", 32'(grant5), 32'h01);
        rel = 1'b1; req5 = 5'b00000;
        cyc();
        rel = 1'b0;

        // Fixed priority: 5 first, then 0 wins whenever present.
        reqf = 8'hA0;
        cyc();
        check("t5_first", 32'(self), 32'd5);
        rel = 1'b1; reqf = 8'hA1;
        cyc();
        rel = 1'b0;
        cyc();
        check("t5_second", 32'(self), 32'd0);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        cyc();
        check("t5_third",       32'(self),   32'd0);
        check("t5_third_grant", 32'(grantf), 32'h01);
        rel = 1'b1; reqf = 8'h00;
        cyc();
        rel = 1'b0;

        // Enable gating and release ignored in IDLE.
        enable = 1'b0; req8 = 8'h10;
        repeat (2) cyc();
        check("t6_gated", 32'(valid8), 32'd0);
        rel = 1'b1;
        cyc();
        check("t6_idle_release", 32'(valid8), 32'd0);
        rel = 1'b0; enable = 1'b1;
        cyc();
        check("t6_enabled_grant", 32'(grant8), 32'h10);
        rel = 1'b1; req8 = 8'h00;
        cyc();
        rel = 1'b0;

        // Random traffic against the model, with occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            if (reset) reset = 1'b0;
            req8   = 8'($urandom & $urandom);
            req5   = 5'($urandom & $urandom);
            reqf   = 8'($urandom & $urandom);
            enable = ($urandom_range(0, 3) != 0);
            rel    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b1;
            end
            cyc();
        end
        reset = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
